// File: rtl/alu_chain_seq.sv
// rtl/alu_chain_seq.sv - 32-bit add/sub sequenced as two passes over an external 16-bit ALU
module alu_chain_seq #(
    parameter int ALU_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_A,
    input  logic [31:0] REQ_B,
    input  logic [3:0]  REQ_OP,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RESULT,
    output logic        RSP_ZERO,
    output logic        RSP_CARRY,
    output logic        RSP_OVERFLOW,
    output logic        RSP_NEGATIVE,
    output logic        RSP_ERR,
    output logic        ALU_EN,
    output logic [15:0] ALU_A,
    output logic [15:0] ALU_B,
    output logic [3:0]  ALU_OPCODE,
    output logic        ALU_CIN,
    input  logic [15:0] ALU_RESULT,
    input  logic        ALU_CARRY,
    input  logic        ALU_OVERFLOW
);

    // alu_pkg opcode encodings for the two supported operations
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        WAIT_LO,
        ISSUE_HI,
        WAIT_HI,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_a_hi;
    logic [15:0] r_b_hi;
    logic        w_supported;
    logic        w_wait_done;

    assign w_supported = (REQ_OP == OP_ADD) || (REQ_OP == OP_SUB);
    assign w_wait_done = (r_cnt == 4'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        ALU_EN    = 1'b0;
        case (r_state)
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    w_next = w_supported ? ISSUE_LO : DONE;
                end
            end
            ISSUE_LO: begin
                ALU_EN = 1'b1;
                w_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_wait_done) begin
                    w_next = ISSUE_HI;
                end
            end
            ISSUE_HI: begin
                ALU_EN = 1'b1;
                w_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (w_wait_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Low word lands in RSP_RESULT[15:0] early; its carry becomes the high-word Cin
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= 4'd0;
            r_a_hi       <= 16'd0;
            r_b_hi       <= 16'd0;
            ALU_A        <= 16'd0;
            ALU_B        <= 16'd0;
            ALU_OPCODE   <= 4'd0;
            ALU_CIN      <= 1'b0;
            RSP_RESULT   <= 32'd0;
            RSP_ZERO     <= 1'b0;
            RSP_CARRY    <= 1'b0;
            RSP_OVERFLOW <= 1'b0;
            RSP_NEGATIVE <= 1'b0;
            RSP_ERR      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (REQ_VALID && w_supported) begin
                        ALU_A      <= REQ_A[15:0];
                        ALU_B      <= REQ_B[15:0];
                        ALU_OPCODE <= REQ_OP;
                        ALU_CIN    <= (REQ_OP == OP_SUB);
                        r_a_hi     <= REQ_A[31:16];
                        r_b_hi     <= REQ_B[31:16];
                        RSP_ERR    <= 1'b0;
                    end else if (REQ_VALID) begin
                        RSP_RESULT   <= 32'd0;
                        RSP_ZERO     <= 1'b0;
                        RSP_CARRY    <= 1'b0;
                        RSP_OVERFLOW <= 1'b0;
                        RSP_NEGATIVE <= 1'b0;
                        RSP_ERR      <= 1'b1;
                    end
                end
                ISSUE_LO, ISSUE_HI: begin
                    r_cnt <= 4'(ALU_LAT - 1);
                end
                WAIT_LO: begin
                    if (w_wait_done) begin
                        RSP_RESULT[15:0] <= ALU_RESULT;
                        ALU_A            <= r_a_hi;
                        ALU_B            <= r_b_hi;
                        ALU_CIN          <= ALU_CARRY;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WAIT_HI: begin
                    if (w_wait_done) begin
                        RSP_RESULT[31:16] <= ALU_RESULT;
                        RSP_CARRY         <= ALU_CARRY;
                        RSP_OVERFLOW      <= ALU_OVERFLOW;
                        RSP_NEGATIVE      <= ALU_RESULT[15];
                        RSP_ZERO          <= (ALU_RESULT == 16'd0) && (RSP_RESULT[15:0] == 16'd0);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_chain_seq.sv
// tb/tb_alu_chain_seq.sv - bench for alu_chain_seq at ALU_LAT=1 and ALU_LAT=3
module tb_alu_chain_seq;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [3:0]  req_op [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_result [2];
    logic        rsp_zero [2];
    logic        rsp_carry [2];
    logic        rsp_overflow [2];
    logic        rsp_negative [2];
    logic        rsp_err [2];
    logic        alu_en [2];
    logic [15:0] alu_a [2];
    logic [15:0] alu_b [2];
    logic [3:0]  alu_op [2];
    logic        alu_cin [2];
    logic [15:0] alu_result [2];
    logic        alu_carry [2];
    logic        alu_ovf [2];

    int vectors = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_chain_seq #(.ALU_LAT(g == 0 ? 1 : 3)) u_dut (
            .CLK(clk), .RST(rst),
            .REQ_VALID(req_valid[g]), .REQ_READY(req_ready[g]),
            .REQ_A(req_a[g]), .REQ_B(req_b[g]), .REQ_OP(req_op[g]),
            .RSP_VALID(rsp_valid[g]), .RSP_READY(rsp_ready[g]),
            .RSP_RESULT(rsp_result[g]), .RSP_ZERO(rsp_zero[g]), .RSP_CARRY(rsp_carry[g]),
            .RSP_OVERFLOW(rsp_overflow[g]), .RSP_NEGATIVE(rsp_negative[g]), .RSP_ERR(rsp_err[g]),
            .ALU_EN(alu_en[g]), .ALU_A(alu_a[g]), .ALU_B(alu_b[g]),
            .ALU_OPCODE(alu_op[g]), .ALU_CIN(alu_cin[g]),
            .ALU_RESULT(alu_result[g]), .ALU_CARRY(alu_carry[g]), .ALU_OVERFLOW(alu_ovf[g])
        );
    end

    // 16-bit ALU: result valid only in the cycle ending ALU_LAT edges after EN was sampled
    function automatic logic [17:0] alu16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [15:0] be;
        logic [16:0] s;
        be = (op == OP_SUB) ? ~b : b;
        s  = {1'b0, a} + {1'b0, be} + {16'd0, cin};
        return {(a[15] == be[15]) && (s[15] != a[15]), s[16], s[15:0]};
    endfunction

    int          pc [2];
    logic [17:0] pv [2];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) pc[k] = 0;
            else if (alu_en[k]) begin
                pv[k] = alu16(alu_a[k], alu_b[k], alu_op[k], alu_cin[k]);
                pc[k] = (k == 0) ? 1 : 3;
            end else if (pc[k] > 0) pc[k] = pc[k] - 1;
            if (pc[k] == 1) {alu_ovf[k], alu_carry[k], alu_result[k]} <= pv[k];
            else {alu_ovf[k], alu_carry[k], alu_result[k]} <= ~pv[k] ^ 18'h0A5A5;
        end
    end

    int          en_cnt [2];
    logic [36:0] iss_log [2][16];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (alu_en[k]) begin
                iss_log[k][en_cnt[k] % 16] = {alu_a[k], alu_b[k], alu_op[k], alu_cin[k]};
                en_cnt[k] = en_cnt[k] + 1;
            end
        end
    end

    // Whole-word reference: {result, zero, carry, overflow, negative, err}
    function automatic logic [36:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [32:0] s;
        logic        c;
        logic        v;
        if (op == OP_ADD) begin
            s = {1'b0, a} + {1'b0, b};
            c = s[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end else if (op == OP_SUB) begin
            s = {1'b0, a - b};
            c = (a >= b);
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            return {32'd0, 5'b00001};
        end
        return {s[31:0], s[31:0] == 32'd0, c, v, s[31], 1'b0};
    endfunction

    function automatic logic [36:0] obs_rsp(input int k);
        return {rsp_result[k], rsp_zero[k], rsp_carry[k], rsp_overflow[k], rsp_negative[k], rsp_err[k]};
    endfunction

    function automatic logic [76:0] obs_all(input int k);
        return {req_ready[k], rsp_valid[k], alu_en[k], obs_rsp(k), alu_a[k], alu_b[k], alu_op[k], alu_cin[k]};
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one request and returns at the first negedge showing RSP_VALID; busy-time REQ_VALID is noise
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, output int lat, output bit tmo);
        @(negedge clk);
        req_valid[k] = 1'b1; req_a[k] = a; req_b[k] = b; req_op[k] = op; rsp_ready[k] = 1'b0;
        @(posedge clk);
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[k]) begin
                tmo = 1'b0;
                break;
            end
            req_valid[k] = 1'($urandom); req_a[k] = $urandom; req_b[k] = $urandom;
            req_op[k] = 4'($urandom);
            @(posedge clk);
        end
        req_valid[k] = 1'b0;
    endtask

    task automatic finish_rsp(input int k);
        req_valid[k] = 1'b1; req_op[k] = OP_ADD; rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0; rsp_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_all(k) !== {1'b1, 76'd0}) begin
                miscompares++;
                $display("FAIL reset_held[%0d]: got %h want %h", k, obs_all(k), {1'b1, 76'd0});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obs_all(k) !== {1'b1, 76'd0}) begin
                miscompares++;
                $display("FAIL reset_released[%0d]: got %h want %h", k, obs_all(k), {1'b1, 76'd0});
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] da [4];
        logic [31:0] db [4];
        logic [3:0]  dop [4];
        logic [36:0] dexp [4];
        logic        lc;
        int          base;
        int          lat;
        bit          tmo;
        da   = '{32'h0001_5678, 32'h0001_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        db   = '{32'h0000_1234, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        dop  = '{OP_SUB, OP_SUB, OP_ADD, OP_ADD};
        dexp = '{{32'h0001_4444, 5'b01000}, {32'h0000_FFFF, 5'b01000},
                 {32'h0000_0000, 5'b11000}, {32'h8000_0000, 5'b00110}};
        for (int i = 0; i < 4; i++) begin
            lc = (dop[i] == OP_SUB) ? (da[i][15:0] >= db[i][15:0])
                                    : ((17'(da[i][15:0]) + 17'(db[i][15:0])) > 17'h0FFFF);
            base = en_cnt[0];
            do_op(0, da[i], db[i], dop[i], lat, tmo);
            vectors++;
            if (tmo || obs_rsp(0) !== dexp[i] || lat != 5) begin
                miscompares++;
                $display("FAIL directed%0d: got %h lat %0d tmo %0d want %h lat 5", i, obs_rsp(0), lat, tmo, dexp[i]);
            end
            vectors++;
            if (en_cnt[0] - base != 2 ||
                iss_log[0][base % 16] !== {da[i][15:0], db[i][15:0], dop[i], dop[i] == OP_SUB} ||
                iss_log[0][(base + 1) % 16] !== {da[i][31:16], db[i][31:16], dop[i], lc}) begin
                miscompares++;
                $display("FAIL directed%0d_issue: got n=%0d lo %h hi %h want lo %h hi %h", i, en_cnt[0] - base,
                         iss_log[0][base % 16], iss_log[0][(base + 1) % 16],
                         {da[i][15:0], db[i][15:0], dop[i], dop[i] == OP_SUB}, {da[i][31:16], db[i][31:16], dop[i], lc});
            end
            finish_rsp(0);
            vectors++;
            if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || alu_a[0] !== da[i][31:16] || alu_cin[0] !== lc) begin
                miscompares++;
                $display("FAIL directed%0d_release: got rdy %b vld %b alu_a %h cin %b want 1 0 %h %b",
                         i, req_ready[0], rsp_valid[0], alu_a[0], alu_cin[0], da[i][31:16], lc);
            end
        end
    endtask

    task automatic test_error();
        logic [3:0]  bad [3];
        logic [36:0] hold_alu;
        int          base;
        int          lat;
        bit          tmo;
        bad = '{4'h2, 4'hF, 4'h7};
        for (int i = 0; i < 3; i++) begin
            base     = en_cnt[0];
            hold_alu = {alu_a[0], alu_b[0], alu_op[0], alu_cin[0]};
            do_op(0, $urandom, $urandom, bad[i], lat, tmo);
            vectors++;
            if (tmo || obs_rsp(0) !== {32'd0, 5'b00001} || lat != 1 || en_cnt[0] != base ||
                {alu_a[0], alu_b[0], alu_op[0], alu_cin[0]} !== hold_alu) begin
                miscompares++;
                $display("FAIL error_op%0d: got %h lat %0d en %0d want %h lat 1 en 0",
                         i, obs_rsp(0), lat, en_cnt[0] - base, {32'd0, 5'b00001});
            end
            finish_rsp(0);
        end
    endtask

    task automatic test_hold();
        logic [38:0] snap;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          tmo;
        a = $urandom;
        b = $urandom;
        do_op(0, a, b, OP_SUB, lat, tmo);
        snap = {1'b1, 1'b0, ref_rsp(a, b, OP_SUB)};
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (tmo || {rsp_valid[0], req_ready[0], obs_rsp(0)} !== snap) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got %h want %h", i, {rsp_valid[0], req_ready[0], obs_rsp(0)}, snap);
            end
            @(negedge clk);
        end
        finish_rsp(0);
        vectors++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: got rdy %b vld %b want 1 0", req_ready[0], rsp_valid[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [36:0] exp;
        int          exp_lat;
        int          lat;
        bit          tmo;
        int          r;
        for (int n = 0; n < 40; n++) begin
            int k;
            k = (n < 30) ? 0 : 1;
            a = rnd_operand();
            b = rnd_operand();
            r = $urandom_range(0, 9);
            op = (r == 0) ? 4'($urandom_range(2, 15)) : (r < 5) ? OP_ADD : OP_SUB;
            exp = ref_rsp(a, b, op);
            exp_lat = exp[0] ? 1 : (k == 0 ? 5 : 9);
            do_op(k, a, b, op, lat, tmo);
            vectors++;
            if (tmo || obs_rsp(k) !== exp || lat != exp_lat) begin
                miscompares++;
                $display("FAIL random%0d[%0d] %h op%0d %h: got %h lat %0d want %h lat %0d",
                         n, k, a, op, b, obs_rsp(k), lat, exp, exp_lat);
            end
            finish_rsp(k);
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  seen;
        int  lat;
        bit  tmo;
        @(negedge clk);
        req_valid[1] = 1'b1; req_a[1] = 32'h0001_5678; req_b[1] = 32'h0000_1234; req_op[1] = OP_SUB;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            @(negedge clk);
            if (alu_en[1]) n++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (n != 2 || obs_all(1) !== {1'b1, 76'd0}) begin
            miscompares++;
            $display("FAIL midrst_async: got %h issues %0d want %h issues 2", obs_all(1), n, {1'b1, 76'd0});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | rsp_valid[1] | alu_en[1];
        end
        vectors++;
        if (seen !== 1'b0 || req_ready[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_quiet: got activity %b rdy %b want 0 1", seen, req_ready[1]);
        end
        do_op(1, 32'h0001_5678, 32'h0000_1234, OP_SUB, lat, tmo);
        vectors++;
        if (tmo || obs_rsp(1) !== {32'h0001_4444, 5'b01000} || lat != 9) begin
            miscompares++;
            $display("FAIL midrst_rerun: got %h lat %0d want %h lat 9", obs_rsp(1), lat, {32'h0001_4444, 5'b01000});
        end
        finish_rsp(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_a[k] = 32'd0; req_b[k] = 32'd0; req_op[k] = 4'd0; rsp_ready[k] = 1'b0;
            en_cnt[k] = 0;
        end
        test_reset();
        test_directed();
        test_error();
        test_hold();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_chain_seq.md
ALU_CHAIN_SEQ -- requirements
Module: alu_chain_seq

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, the cycles from the edge sampling EN=1 to ALU Result/flags being valid (legal range 1..15).
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  block accepts a request.
- REQ_A  in  32  minuend/addend.
- REQ_B  in  32  subtrahend/addend.
- REQ_OP  in  4  alu_pkg opcode; only OP_ADD and OP_SUB supported.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  consumer accepts response.
- RSP_RESULT  out  32  32-bit result.
- RSP_ZERO, RSP_CARRY, RSP_OVERFLOW, RSP_NEGATIVE  out  1 each  32-bit flags.
- RSP_ERR  out  1  unsupported opcode.
- ALU_EN  out  1  EN to ALU_16bit.
- ALU_A, ALU_B  out  16 each  ALU operands.
- ALU_OPCODE  out  4  ALU OpCode.
- ALU_CIN  out  1  ALU Cin.
- ALU_RESULT  in  16  ALU Result.
- ALU_CARRY, ALU_OVERFLOW  in  1 each  ALU Carry/Overflow.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE.
REQ-004 REQ_READY SHALL be 1 only in IDLE; a request is accepted on a rising edge with REQ_VALID=1 in IDLE, capturing REQ_A/REQ_B/REQ_OP.
REQ-005 On acceptance, OP_ADD/OP_SUB SHALL go to ISSUE_LO; any other opcode SHALL go to DONE with RSP_ERR=1, RSP_RESULT=0, all flags 0, and no ALU_EN pulse.
REQ-006 ISSUE_LO and ISSUE_HI SHALL each last exactly one cycle with ALU_EN=1; ALU_EN SHALL be 0 in every other state.
REQ-007 In ISSUE_LO/WAIT_LO, ALU_A/ALU_B SHALL be the low 16 bits of the captured operands; ALU_CIN SHALL be 1 for OP_SUB (no-borrow) and 0 for OP_ADD.
REQ-008 In ISSUE_HI/WAIT_HI, ALU_A/ALU_B SHALL be the high 16 bits; ALU_CIN SHALL be the captured low-word ALU_CARRY.
REQ-009 ALU_OPCODE SHALL equal the captured opcode from ISSUE_LO through WAIT_HI; ALU_A/ALU_B/ALU_OPCODE/ALU_CIN SHALL hold their last values in IDLE and DONE.
REQ-010 WAIT_LO and WAIT_HI SHALL each last exactly ALU_LAT cycles, counted by an internal counter; ALU_RESULT/ALU_CARRY/ALU_OVERFLOW are sampled on the edge ending the last WAIT cycle.
REQ-011 Low word result SHALL be RSP_RESULT[15:0]; high word SHALL be RSP_RESULT[31:16].
REQ-012 RSP_CARRY and RSP_OVERFLOW SHALL be the high-word ALU_CARRY and ALU_OVERFLOW; RSP_NEGATIVE SHALL be RSP_RESULT[31]; RSP_ZERO SHALL be 1 iff RSP_RESULT==0, computed locally.
REQ-013 RSP_VALID SHALL be 1 only in DONE; RSP_* SHALL be stable while RSP_VALID=1 and RSP_READY=0.
REQ-014 DONE SHALL go to IDLE on an edge with RSP_READY=1; no request is accepted in that same cycle.
REQ-015 Latency: RSP_VALID SHALL first assert 2*ALU_LAT+3 cycles after the accept edge for supported ops (5 for ALU_LAT=1), and 1 cycle after it for errors.
REQ-016 REQ_VALID outside IDLE SHALL be ignored, with no effect on the in-flight operation.
REQ-017 A carry of 1 out of the high word SHALL be reported only via RSP_CARRY; the result wraps modulo 2^32.

Reset
REQ-018 RST=1 SHALL asynchronously force IDLE, WAIT counter 0, ALU_EN=0, ALU_A/ALU_B/ALU_OPCODE/ALU_CIN=0, RSP_VALID=0, RSP_RESULT=0, all RSP flags 0, RSP_ERR=0, REQ_READY=1.
REQ-019 RST asserted mid-operation SHALL abort it with no response; after release, the first edge with REQ_VALID=1 SHALL be accepted.

Verification
REQ-020 SUB 0x0001_5678 - 0x0000_1234, ALU_LAT=1 -> RSP_RESULT=0x0001_4444, CARRY=1, ZERO=0; RSP_VALID 5 cycles after accept; low-issue ALU_CIN=1.
REQ-021 SUB 0x0001_0000 - 0x0000_0001 -> low 0xFFFF with carry 0; high ALU_CIN=0; RSP_RESULT=0x0000_FFFF, CARRY=1, NEGATIVE=0.
REQ-022 ADD 0xFFFF_FFFF + 0x0000_0001 -> RSP_RESULT=0, ZERO=1, CARRY=1; ADD 0x7FFF_FFFF + 1 -> 0x8000_0000, OVERFLOW=1, NEGATIVE=1.
REQ-023 Unsupported opcode -> RSP_ERR=1 one cycle after accept, result/flags 0, ALU_EN never 1.
REQ-024 RSP_READY held 0 for 4 cycles in DONE -> RSP_* stable, REQ_READY=0; RSP_READY=1 -> IDLE next cycle.
REQ-025 RST pulsed during WAIT_HI, then ALU_LAT=3 run of test REQ-020 -> ALU_EN drops immediately, no RSP_VALID; rerun gives same result with RSP_VALID 9 cycles after accept.
